// File: rtl/unidade_controle_exp3.sv
`default_nettype none
// ============================================================================
// unidade_controle_exp3 : Moore control FSM sequencing the Exp2 counter/comparator datapath.
// Optional macro TIMEOUT_EN adds a bounded wait (TIMEOUT_CYCLES) for each play in ESPERA.
// Revision: 1.0 - initial release
// ============================================================================
module unidade_controle_exp3 #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zera,
  output logic       conta,
  output logic       registra,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  // State codes double as the debug display value.
  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARA     = 4'h1;
  localparam logic [3:0] ESPERA      = 4'h2;
  localparam logic [3:0] REGISTRA    = 4'h4;
  localparam logic [3:0] COMPARA     = 4'h5;
  localparam logic [3:0] PROXIMO     = 4'h6;
  localparam logic [3:0] FIM_ACERTOU = 4'hA;
  localparam logic [3:0] FIM_ERROU   = 4'hE;

  if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [3:0] estado_q, estado_d;
  logic       jogada_q;
  logic       jogada_edge;
  logic       timeout_hit;
  logic       tflag;

  assign jogada_edge = jogada & ~jogada_q;

`ifdef TIMEOUT_EN
  localparam int              TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          tflag_q, tflag_d;

  // A play arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (estado_q == ESPERA) && (cnt_q == CNT_LAST) && !jogada_edge;
  assign tflag       = tflag_q;

  always_comb begin
    cnt_d   = (estado_q == ESPERA) ? cnt_q + 1'b1 : '0;
    tflag_d = tflag_q;
    if (timeout_hit) begin
      tflag_d = 1'b1;
    end else if (estado_q == PREPARA) begin
      tflag_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign tflag       = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:     if (iniciar) estado_d = PREPARA;
      PREPARA:     estado_d = ESPERA;
      ESPERA: begin
        if (jogada_edge)      estado_d = REGISTRA;
        else if (timeout_hit) estado_d = FIM_ERROU;
      end
      REGISTRA:    estado_d = COMPARA;
      COMPARA: begin
        if (!igual)   estado_d = FIM_ERROU;
        else if (fim) estado_d = FIM_ACERTOU;
        else          estado_d = PROXIMO;
      end
      PROXIMO:     estado_d = ESPERA;
      FIM_ACERTOU: if (iniciar) estado_d = PREPARA;
      FIM_ERROU:   if (iniciar) estado_d = PREPARA;
      default:     estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      jogada_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      jogada_q <= jogada;
    end
  end

  always_comb begin
    zera      = 1'b0;
    conta     = 1'b0;
    registra  = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = estado_q;
    case (estado_q)
      INICIAL, ESPERA, COMPARA: ;
      PREPARA:  zera     = 1'b1;
      REGISTRA: registra = 1'b1;
      PROXIMO:  conta    = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = tflag;
      end
      default:  db_estado = 4'hF;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_exp3.sv
`default_nettype none
// ============================================================================
// tb_unidade_controle_exp3 : scoreboard bench for the Exp3 control FSM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_unidade_controle_exp3;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, jogada, igual, fim;
  logic       zera, conta, registra, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  logic [10:0] obs;
  logic [10:0] exp_v;
  logic [10:0] sb [$];
  int checks = 0;
  int errors = 0;

  unidade_controle_exp3 #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fim(fim), .zera(zera), .conta(conta), .registra(registra),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  assign obs = {db_estado, zera, conta, registra, pronto, acertou, errou, timeout};

  // Expected outputs per state, from the state/output table.
  function automatic logic [10:0] exp_out(input logic [3:0] st, input logic to);
    case (st)
      4'h0:    return {4'h0, 7'b0000000};
      4'h1:    return {4'h1, 7'b1000000};
      4'h2:    return {4'h2, 7'b0000000};
      4'h4:    return {4'h4, 7'b0010000};
      4'h5:    return {4'h5, 7'b0000000};
      4'h6:    return {4'h6, 7'b0100000};
      4'hA:    return {4'hA, 7'b0001100};
      4'hE:    return {4'hE, 6'b000101, to};
      default: return {4'hF, 7'b0000000};
    endcase
  endfunction

  // One step: inputs held for a cycle, and the state expected after that edge.
  function automatic logic [8:0] stp(input int ini, input int jog, input int ig,
                                     input int fi, input int to, input int st);
    return {ini[0], jog[0], ig[0], fi[0], to[0], st[3:0]};
  endfunction

  task automatic apply(input logic [8:0] s);
    iniciar = s[8];
    jogada  = s[7];
    igual   = s[6];
    fim     = s[5];
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fim = 1'b0;
    #12;
    checks++;
    if (obs !== 11'h000) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, 11'h000);
    end
    @(negedge clock); reset = 1'b1; iniciar = 1'b1;
    sb.push_back(exp_out(4'h1, 1'b0));
    @(posedge clock); #1;
    checks++; exp_v = sb.pop_front();
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_enter_prepara: got %h expected %h", obs, exp_v);
    end
    #2 reset = 1'b0; iniciar = 1'b0;
    #1;
    checks++;
    if (obs !== 11'h000) begin
      errors++; $display("FAIL reset_async_abort: got %h expected %h", obs, 11'h000);
    end
    @(posedge clock); #1;
    checks++;
    if (obs !== 11'h000) begin
      errors++; $display("FAIL reset_held: got %h expected %h", obs, 11'h000);
    end
    reset = 1'b1;
  endtask

  task automatic test_start();
    logic [8:0] t [$];
    t = '{stp(1,0,0,0,0,1), stp(0,0,0,0,0,2), stp(0,0,0,0,0,2), stp(0,0,0,0,0,2)};
    foreach (t[i]) begin
      sb.push_back(exp_out(t[i][3:0], t[i][4]));
      apply(t[i]);
      @(posedge clock); #1;
      checks++; exp_v = sb.pop_front();
      if (obs !== exp_v) begin
        errors++; $display("FAIL start step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_plays();
    logic [8:0] t [$];
    for (int p = 0; p < 3; p++) begin
      t.push_back(stp(0,1,1,0,0,4));
      t.push_back(stp(0,1,1,0,0,5));
      t.push_back(stp(0,0,1,0,0,6));
      t.push_back(stp(0,0,1,0,0,2));
    end
    foreach (t[i]) begin
      sb.push_back(exp_out(t[i][3:0], t[i][4]));
      apply(t[i]);
      @(posedge clock); #1;
      checks++; exp_v = sb.pop_front();
      if (obs !== exp_v) begin
        errors++; $display("FAIL plays step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_acertou();
    logic [8:0] t [$];
    t = '{stp(0,1,1,1,0,4), stp(0,1,1,1,0,5), stp(0,0,1,1,0,10), stp(0,0,1,1,0,10),
          stp(1,0,0,0,0,1), stp(0,0,0,0,0,2)};
    foreach (t[i]) begin
      sb.push_back(exp_out(t[i][3:0], t[i][4]));
      apply(t[i]);
      @(posedge clock); #1;
      checks++; exp_v = sb.pop_front();
      if (obs !== exp_v) begin
        errors++; $display("FAIL acertou step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_errou_hold();
    logic [8:0] t [$];
    t = '{stp(0,1,0,0,0,4), stp(0,1,0,0,0,5), stp(0,1,0,0,0,14), stp(0,1,0,0,0,14),
          stp(1,1,0,0,0,1), stp(1,1,0,0,0,2), stp(1,1,0,0,0,2), stp(0,1,0,0,0,2),
          stp(0,0,0,0,0,2), stp(0,1,1,0,0,4), stp(0,1,1,0,0,5), stp(0,1,1,0,0,6),
          stp(0,0,0,0,0,2)};
    foreach (t[i]) begin
      sb.push_back(exp_out(t[i][3:0], t[i][4]));
      apply(t[i]);
      @(posedge clock); #1;
      checks++; exp_v = sb.pop_front();
      if (obs !== exp_v) begin
        errors++; $display("FAIL errou_hold step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    logic [8:0] t [$];
    t = '{stp(0,1,0,0,0,4), stp(0,1,0,0,0,5), stp(0,0,0,0,0,14),
          stp(1,0,0,0,0,1), stp(0,0,0,0,0,2)};
    for (int k = 0; k < 7; k++) t.push_back(stp(0,0,0,0,0,2));
    t.push_back(stp(0,0,0,0,1,14));
    t.push_back(stp(1,0,0,0,0,1));
    t.push_back(stp(0,0,0,0,0,2));
    for (int k = 0; k < 7; k++) t.push_back(stp(0,0,0,0,0,2));
    t.push_back(stp(0,1,1,0,0,4));
    t.push_back(stp(0,1,1,0,0,5));
    t.push_back(stp(0,0,1,0,0,6));
    t.push_back(stp(0,0,1,0,0,2));
    t.push_back(stp(0,1,0,0,0,4));
    t.push_back(stp(0,1,0,0,0,5));
    t.push_back(stp(0,0,0,0,0,14));
    foreach (t[i]) begin
      sb.push_back(exp_out(t[i][3:0], t[i][4]));
      apply(t[i]);
      @(posedge clock); #1;
      checks++; exp_v = sb.pop_front();
      if (obs !== exp_v) begin
        errors++; $display("FAIL timeout step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start();
    test_plays();
    test_acertou();
    test_errou_hold();
`ifdef TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
